// File: rtl/pang_sft_ctrl_pkg.sv
// Shared types and constants for the lane-shift controller and its offset arithmetic.
`include "macro_para.v"

package pang_sft_ctrl_pkg;

   // Lane count expressed in the length width and in the wider sum width.
   localparam logic [`SFT_BIT:0]   LANES_LEN = (`SFT_BIT+1)'(1) << `SFT_BIT;
   localparam logic [`SFT_BIT+1:0] LANES_SUM = (`SFT_BIT+2)'(1) << `SFT_BIT;

   typedef struct packed {
      logic [`SFT_BIT-1:0] nxt_off;
      logic [`SFT_BIT-1:0] end_lane;
      logic                full;
      logic                adv;
   } calc_t;

   function automatic logic [`SFT_BIT:0] clamp_len(input logic [`SFT_BIT:0] len);
      return (len > LANES_LEN) ? LANES_LEN : len;
   endfunction

endpackage

// File: rtl/macro_para.v
// Shared lane-geometry macros: 16 lanes per block, addressed by a 4-bit lane index.
`ifndef MACRO_PARA_V
`define MACRO_PARA_V
`define SFT_BIT     4
`define SUB_BLK_BIT 4
`endif

// File: rtl/pang_sft_calc.sv
// Combinational window arithmetic: next offset, last lane and boundary flags for one request.
`include "macro_para.v"

module pang_sft_calc
   import pang_sft_ctrl_pkg::*;
(
   input  logic [`SFT_BIT-1:0] off,
   input  logic [`SFT_BIT:0]   len,
   output calc_t               res
);

   logic [`SFT_BIT:0]   len_c;
   logic [`SFT_BIT+1:0] sum;
   logic [`SFT_BIT+1:0] last;

   always_comb begin
      len_c = clamp_len(len);
      sum   = {2'b00, off} + {1'b0, len_c};
      last  = sum - (`SFT_BIT+2)'(1);
      res   = '0;
      // An empty request is a zero-width window anchored at the current offset.
      if (len_c == '0) begin
         res.nxt_off  = off;
         res.end_lane = off;
      end else begin
         res.nxt_off  = sum[`SFT_BIT-1:0];
         res.end_lane = last[`SFT_BIT-1:0];
         res.full     = (sum > LANES_SUM);
         res.adv      = (sum >= LANES_SUM);
      end
   end

endmodule

// File: rtl/pang_sft_ctrl.sv
// Lane-shift controller: one-entry registered control word, valid/ready on both sides, sync flush.
// Define PANG_SFT_STAT_EN to add the saturating wrap_cnt statistics port.
`include "macro_para.v"

module pang_sft_ctrl
   import pang_sft_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [`SFT_BIT:0]   in_len,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [`SFT_BIT-1:0] next_sft,
   output logic                need_full,
   output logic [`SFT_BIT-1:0] need_pang_start_inc,
   output logic [`SFT_BIT-1:0] need_pang_end_inc,
   output logic                blk_adv
`ifdef PANG_SFT_STAT_EN
   ,
   output logic [15:0]         wrap_cnt
`endif
);

   logic [`SFT_BIT-1:0] off;
   calc_t               res;
   logic                accept;

   pang_sft_calc u_calc (
      .off (off),
      .len (in_len),
      .res (res)
   );

   assign in_ready = (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         off                 <= '0;
         out_valid           <= 1'b0;
         next_sft            <= '0;
         need_full           <= 1'b0;
         need_pang_start_inc <= '0;
         need_pang_end_inc   <= '0;
         blk_adv             <= 1'b0;
      end else if (flush) begin
         off       <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         off                 <= res.nxt_off;
         out_valid           <= 1'b1;
         next_sft            <= off;
         need_pang_start_inc <= off;
         need_pang_end_inc   <= res.end_lane;
         need_full           <= res.full;
         blk_adv             <= res.adv;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PANG_SFT_STAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_cnt <= '0;
      end else if (flush) begin
         wrap_cnt <= '0;
      end else if (out_valid && out_ready && blk_adv && (wrap_cnt != 16'hFFFF)) begin
         wrap_cnt <= wrap_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pang_sft_ctrl.sv
// Directed bench for pang_sft_ctrl: offsets, wraps, clamping, backpressure, flush and reset.
`timescale 1ns/1ps

module tb_pang_sft_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_len;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] next_sft;
   logic       need_full;
   logic [3:0] need_pang_start_inc;
   logic [3:0] need_pang_end_inc;
   logic       blk_adv;
`ifdef PANG_SFT_STAT_EN
   logic [15:0] wrap_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pang_sft_ctrl dut (
      .clk                 (clk),
      .reset               (reset),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_len              (in_len),
      .flush               (flush),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .next_sft            (next_sft),
      .need_full           (need_full),
      .need_pang_start_inc (need_pang_start_inc),
      .need_pang_end_inc   (need_pang_end_inc),
      .blk_adv             (blk_adv)
`ifdef PANG_SFT_STAT_EN
      ,
      .wrap_cnt            (wrap_cnt)
`endif
   );

   // Observed control word packed as {out_valid, next_sft, start, end, need_full, blk_adv}.
   function automatic logic [14:0] word();
      return {out_valid, next_sft, need_pang_start_inc, need_pang_end_inc, need_full, blk_adv};
   endfunction

   // Present one request for a single cycle; the result is visible at the following negedge.
   task automatic issue(input logic [4:0] len);
      in_valid = 1'b1;
      in_len   = len;
      @(negedge clk);
      in_valid = 1'b0;
      in_len   = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_len = '0; flush = 1'b0; out_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      n_vec++;
      if (word() !== 15'h0000) begin
         n_err++; $display("FAIL reset_word got=%h exp=%h", word(), 15'h0000);
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_offsets();
      // off 0 + 5: start 0, end 4, off -> 5
      issue(5'd5);
      n_vec++;
      if (word() !== {1'b1, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL first_len5 got=%h exp=%h", word(), {1'b1, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0});
      end
      // off 5 + 8: end 12, off -> 13
      issue(5'd8);
      n_vec++;
      if (word() !== {1'b1, 4'd5, 4'd5, 4'd12, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL len8_off5 got=%h exp=%h", word(), {1'b1, 4'd5, 4'd5, 4'd12, 1'b0, 1'b0});
      end
      // off 13 + 6 = 19: crosses boundary, end 2, off -> 3
      issue(5'd6);
      n_vec++;
      if (word() !== {1'b1, 4'd13, 4'd13, 4'd2, 1'b1, 1'b1}) begin
         n_err++; $display("FAIL cross_off13 got=%h exp=%h", word(), {1'b1, 4'd13, 4'd13, 4'd2, 1'b1, 1'b1});
      end
      // off 3 + 7: end 9, off -> 10
      issue(5'd7);
      n_vec++;
      if (word() !== {1'b1, 4'd3, 4'd3, 4'd9, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL len7_off3 got=%h exp=%h", word(), {1'b1, 4'd3, 4'd3, 4'd9, 1'b0, 1'b0});
      end
      // off 10 + 6 = 16: exact boundary, end 15, off -> 0
      issue(5'd6);
      n_vec++;
      if (word() !== {1'b1, 4'd10, 4'd10, 4'd15, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL exact_wrap got=%h exp=%h", word(), {1'b1, 4'd10, 4'd10, 4'd15, 1'b0, 1'b1});
      end
      // off 0 + 3 confirms the wrapped offset; off -> 3
      issue(5'd3);
      n_vec++;
      if (word() !== {1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL after_wrap got=%h exp=%h", word(), {1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0});
      end
   endtask

   task automatic test_len_zero();
      // off 3 + 0: start = end = 3, off unchanged
      issue(5'd0);
      n_vec++;
      if (word() !== {1'b1, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL len0 got=%h exp=%h", word(), {1'b1, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0});
      end
      // off 3 + 2: end 4, off -> 5
      issue(5'd2);
      n_vec++;
      if (word() !== {1'b1, 4'd3, 4'd3, 4'd4, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL len0_off_kept got=%h exp=%h", word(), {1'b1, 4'd3, 4'd3, 4'd4, 1'b0, 1'b0});
      end
   endtask

   task automatic test_clamp();
      // off 5 + 20 clamps to 16: sum 21, end 4, off stays 5
      issue(5'd20);
      n_vec++;
      if (word() !== {1'b1, 4'd5, 4'd5, 4'd4, 1'b1, 1'b1}) begin
         n_err++; $display("FAIL clamp20 got=%h exp=%h", word(), {1'b1, 4'd5, 4'd5, 4'd4, 1'b1, 1'b1});
      end
      // off 5 + 1: end 5, off -> 6
      issue(5'd1);
      n_vec++;
      if (word() !== {1'b1, 4'd5, 4'd5, 4'd5, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL clamp_off_kept got=%h exp=%h", word(), {1'b1, 4'd5, 4'd5, 4'd5, 1'b0, 1'b0});
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL idle_drain got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      // off 6 + 4: end 9, off -> 10
      issue(5'd4);
      in_valid = 1'b1;
      in_len   = 5'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if ({in_ready, word()} !== {1'b0, 1'b1, 4'd6, 4'd6, 4'd9, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL stall_%0d got=%h exp=%h", i, {in_ready, word()}, {1'b0, 1'b1, 4'd6, 4'd6, 4'd9, 1'b0, 1'b0});
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL release_ready got=%b exp=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      // off 10 + 2: end 11, off -> 12
      n_vec++;
      if (word() !== {1'b1, 4'd10, 4'd10, 4'd11, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL release_word got=%h exp=%h", word(), {1'b1, 4'd10, 4'd10, 4'd11, 1'b0, 1'b0});
      end
   endtask

   task automatic test_flush();
      // off 12 + 11 = 23: end 6, off -> 7
      issue(5'd11);
      n_vec++;
      if (word() !== {1'b1, 4'd12, 4'd12, 4'd6, 1'b1, 1'b1}) begin
         n_err++; $display("FAIL pre_flush got=%h exp=%h", word(), {1'b1, 4'd12, 4'd12, 4'd6, 1'b1, 1'b1});
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_len   = 5'd3;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL flush_in_ready got=%b exp=0", in_ready);
      end
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL flush_out_valid got=%b exp=0", out_valid);
      end
      // Dropped request leaves offset at 0: start 0, end 1
      issue(5'd2);
      n_vec++;
      if (word() !== {1'b1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL post_flush got=%h exp=%h", word(), {1'b1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_midstream_reset();
      // off 2 + 3 -> off 5, then async reset between clock edges
      issue(5'd3);
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if (word() !== 15'h0000) begin
         n_err++; $display("FAIL async_reset got=%h exp=%h", word(), 15'h0000);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(5'd4);
      n_vec++;
      if (word() !== {1'b1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL after_reset got=%h exp=%h", word(), {1'b1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0});
      end
      @(negedge clk);
   endtask

`ifdef PANG_SFT_STAT_EN
   task automatic test_wrap_cnt();
      n_vec++;
      if (wrap_cnt !== 16'd0) begin
         n_err++; $display("FAIL wrap_cnt_start got=%0d exp=0", wrap_cnt);
      end
      for (int i = 0; i < 4; i++) issue(5'd16);
      @(negedge clk);
      n_vec++;
      if (wrap_cnt !== 16'd4) begin
         n_err++; $display("FAIL wrap_cnt_4 got=%0d exp=4", wrap_cnt);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_vec++;
      if (wrap_cnt !== 16'd0) begin
         n_err++; $display("FAIL wrap_cnt_flush got=%0d exp=0", wrap_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_offsets();
      test_len_zero();
      test_clamp();
      test_backpressure();
      test_flush();
      test_midstream_reset();
`ifdef PANG_SFT_STAT_EN
      test_wrap_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
